sram_controller: RTL and testbench

//  MEM-stage initiator for the off-chip 16-bit SRAM; replaces the on-chip data memory in the ARM pipeline.

---
 rtl/sram_controller.sv | 148 ++++++++++++++
 tb/tb_sram_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: MEM-stage bridge from 32-bit load/store requests to a
// 16-bit asynchronous SRAM (two half-word accesses plus a recovery wait).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wrEn, rdEn               store / load request (held while ready=0)
//   address, writeData       byte address and store data
//   readData                 registered load result
//   ready                    0 = freeze pipeline, 1 = idle or completing
//   SRAM_DQ                  bidirectional half-word data bus
//   SRAM_ADDR, SRAM_WE_N     half-word address and write strobe
//   SRAM_CE_N/OE_N/UB_N/LB_N permanently enabled (tied 0)
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn,
    input  logic               rdEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               is_wr_q;
    logic [15:0]        wdata_hi_q;
    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] addr_q;
    logic               we_n_q;
    logic               dq_oe_q;
    logic [15:0]        dq_out_q;
    logic [CW-1:0]      cnt_q;

    // Word index: offset from the data base, byte lane and upper bits dropped
    logic [31:0]        off;
    logic [SRAM_AW-2:0] req_idx;
    logic               unused_off_bits;

    assign off             = address - 32'(BASE_ADDR);
    assign req_idx         = off[SRAM_AW:2];
    assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (wrEn || rdEn) begin
                        // Write wins when both are requested
                        state_q    <= S_LOW;
                        is_wr_q    <= wrEn;
                        wdata_hi_q <= writeData[31:16];
                        addr_q     <= {req_idx, 1'b0};
                        we_n_q     <= ~wrEn;
                        dq_oe_q    <= wrEn;
                        dq_out_q   <= writeData[15:0];
                    end
                end
                S_LOW: begin
                    if (!is_wr_q) begin
                        rdata_q[15:0] <= SRAM_DQ;
                    end
                    state_q  <= S_HIGH;
                    addr_q   <= {addr_q[SRAM_AW-1:1], 1'b1};
                    we_n_q   <= ~is_wr_q;
                    dq_oe_q  <= is_wr_q;
                    dq_out_q <= wdata_hi_q;
                end
                S_HIGH: begin
                    if (!is_wr_q) begin
                        rdata_q[31:16] <= SRAM_DQ;
                    end
                    state_q <= S_WAIT;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Held request is not re-accepted until the next IDLE cycle
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output enable and WE_N come from the same transition, so DQ is
    // only driven while WE_N is low.
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign readData  = rdata_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    always_comb begin
        ready = 1'b0;
        if (state_q == S_IDLE) begin
            ready = ~(wrEn | rdEn);
        end else if (state_q == S_DONE) begin
            ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized load/store traffic against an SRAM model
// and a word-level reference memory, plus directed literal cases.
module tb_sram_controller;

    localparam int W   = 3;
    localparam int LAT = 3 + W;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn, rdEn;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] sa;
    logic        we_n, ce_n, oe_n, ub_n, lb_n;

    logic [15:0] sram [0:262143];
    logic [15:0] mdl [int];
    logic [31:0] exp_rd = 32'h0;
    bit          in_op = 1'b1;
    bit          init_done = 1'b0;
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    sram_controller #(
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(W),
        .SRAM_AW    (18)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .rdEn     (rdEn),
        .address  (address),
        .writeData(writeData),
        .readData (readData),
        .ready    (ready),
        .SRAM_DQ  (dq),
        .SRAM_ADDR(sa),
        .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n)
    );

    // Asynchronous SRAM: drives the bus whenever not being written
    assign dq = we_n ? sram[sa] : 16'bz;

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] mget(int a);
        return mdl.exists(a) ? mdl[a] : 16'h0;
    endfunction

    // SRAM write capture mid-cycle, then per-cycle output checks
    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
            init_done = 1'b1;
        end
        if (!we_n) begin
            sram[sa] = dq;
            wr_cnt++;
        end
        #2;
        check("ce_n", {31'h0, ce_n}, 32'h0);
        check("oe_n", {31'h0, oe_n}, 32'h0);
        check("ub_lb_n", {30'h0, ub_n, lb_n}, 32'h0);
        if (!in_op) begin
            check("idle_rdata", readData, exp_rd);
            check("idle_we_n", {31'h0, we_n}, 32'h1);
            if (!wrEn && !rdEn && !rst)
                check("idle_ready", {31'h0, ready}, 32'h1);
        end else if (wrEn) begin
            check("store_keeps_rdata", readData, exp_rd);
        end
    end

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input bit scramble);
        logic [31:0] off;
        int idx, lo, hi, w0, cnt;
        bit done;
        off  = a - 32'd1024;
        idx  = int'((off >> 2) & 32'h1ffff);
        lo   = idx * 2;
        hi   = lo + 1;
        w0   = wr_cnt;
        cnt  = 0;
        done = 1'b0;
        wrEn = wr;
        rdEn = rd;
        address = a;
        writeData = d;
        in_op = 1'b1;
        if (wr) begin
            mdl[lo] = d[15:0];
            mdl[hi] = d[31:16];
        end else if (rd) begin
            exp_rd = {mget(hi), mget(lo)};
        end
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (!ready) cnt++;
            else if (cnt > 0) done = 1'b1;
            if (!done) begin
                @(negedge clk);
                if (scramble && cnt > 0) begin
                    address = $urandom;
                    writeData = $urandom;
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: got no ready after %0d low cycles", cnt);
        end
        check("latency", cnt, LAT);
        if (done) check("done_rdata", readData, exp_rd);
        check("write_pulses", wr_cnt - w0, wr ? 2 : 0);
        if (wr) begin
            check("mem_lo", {16'h0, sram[lo]}, {16'h0, mget(lo)});
            check("mem_hi", {16'h0, sram[hi]}, {16'h0, mget(hi)});
        end
        in_op = 1'b0;
    endtask

    task automatic idle(input int n);
        wrEn = 1'b0;
        rdEn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        wrEn = 1'b0;
        rdEn = 1'b0;
        address = 32'h0;
        writeData = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_rdata", readData, 32'h0);
        check("rst_we_n", {31'h0, we_n}, 32'h1);
        check("rst_addr", {14'h0, sa}, 32'h0);
        rst = 1'b0;
        in_op = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        check("t1_sram0", {16'h0, sram[0]}, 32'h0000BEEF);
        check("t1_sram1", {16'h0, sram[1]}, 32'h0000DEAD);
        idle(2);
        do_op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        check("t2_rdata", readData, 32'hDEADBEEF);
        idle(2);
        do_op(1'b1, 1'b0, 32'd1031, 32'h12345678, 1'b0);
        idle(1);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        check("t3_rdata", readData, 32'h12345678);
        check("t3_sram2", {16'h0, sram[2]}, 32'h00005678);
        check("t3_sram3", {16'h0, sram[3]}, 32'h00001234);
        idle(1);
        do_op(1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, 1'b0);
        check("t4_sram8", {16'h0, sram[8]}, 32'h00005A5A);
        check("t4_sram9", {16'h0, sram[9]}, 32'h0000A5A5);
        check("t4_rdata", readData, 32'h12345678);
        idle(1);
        do_op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        check("t6_first", readData, 32'hDEADBEEF);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        check("t6_second", readData, 32'h12345678);
        idle(5);

        // Reset in the middle of a load's wait period
        rdEn = 1'b1;
        address = 32'd1040;
        in_op = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t5_busy", {31'h0, ready}, 32'h0);
        rst = 1'b1;
        rdEn = 1'b0;
        @(negedge clk);
        #1;
        check("t5_ready", {31'h0, ready}, 32'h1);
        check("t5_rdata", readData, 32'h0);
        check("t5_we_n", {31'h0, we_n}, 32'h1);
        rst = 1'b0;
        exp_rd = 32'h0;
        in_op = 1'b0;
        @(negedge clk);
        do_op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        check("t5_reload", readData, 32'hDEADBEEF);
        idle(1);

        // Randomized traffic against the word-level model
        for (int n = 0; n < 150; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'd1024 + 32'($urandom_range(0, 63));
            do_op(r < 4, r >= 3, a, $urandom, $urandom_range(0, 1) == 1);
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
